// File: rtl/cvp_mem_pkg.sv
// Shared types for the CVP14 staticram arbiter: sequencer states, read-owner
// tags and default bus widths.
package cvp_mem_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SINGLE,
    ST_BURST
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM,
    OWN_VM
  } owner_t;

endpackage

// File: rtl/cvp_burst_ctr.sv
// VM burst bookkeeping: remembers the last issued beat address and how many
// beats remain; beat_addr is the address of the next beat to issue.
module cvp_burst_ctr
  import cvp_mem_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          Clk1,
  input  logic          Reset_n,
  input  logic          load,
  input  logic          advance,
  input  logic [3:0]    len,
  input  logic [AW-1:0] start_addr,
  output logic [AW-1:0] beat_addr,
  output logic          last
);

  logic [AW-1:0] burst_addr;
  logic [3:0]    beat_cnt;

  // beat_cnt counts beats still to issue after the one being issued at load;
  // len=0 wraps to 15, giving a 16-beat burst.
  always_ff @(posedge Clk1) begin
    if (!Reset_n) begin
      burst_addr <= '0;
      beat_cnt   <= '0;
    end else if (load) begin
      burst_addr <= start_addr;
      beat_cnt   <= len - 4'd1;
    end else if (advance) begin
      burst_addr <= beat_addr;
      beat_cnt   <= beat_cnt - 4'd1;
    end
  end

  assign beat_addr = burst_addr + AW'(1);
  assign last      = (beat_cnt == 4'd1);

endmodule

// File: rtl/cvp_mem_arbiter.sv
// Single-port staticram arbiter for CVP14 IF/DM/VM requesters with registered
// RAM strobes, starvation promotion for IF and non-interruptible VM bursts.
//
//   state     | meaning
//   ST_IDLE   | no access issued last edge; arbitrate
//   ST_SINGLE | one IF/DM access (or 1-beat VM) in its RAM cycle; arbitrate
//   ST_BURST  | VM burst in progress; issue one beat per edge, no arbitration
module cvp_mem_arbiter
  import cvp_mem_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int STARVE = 4
) (
  input  logic          Clk1,
  input  logic          Reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_valid,
  input  logic          vm_req,
  input  logic          vm_we,
  input  logic [AW-1:0] vm_addr,
  input  logic [3:0]    vm_len,
  input  logic [DW-1:0] vm_wdata,
  output logic          vm_gnt,
  output logic          vm_valid,
  output logic          vm_done,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] Mem_Addr,
  output logic [DW-1:0] Mem_DataOut,
  output logic          Mem_RD,
  output logic          Mem_WR,
  input  logic [DW-1:0] Mem_DataIn
);

  localparam int              SW         = $clog2(STARVE + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE);

  state_t        state, state_nxt;
  owner_t        iss_owner, rd_owner;
  logic          iss_we, iss_done, ctr_load, ctr_adv, ctr_last, burst_we;
  logic          arb_en, promote, win_if, win_dm, win_vm;
  logic [AW-1:0] iss_addr, ctr_addr;
  logic [DW-1:0] iss_data;
  logic [SW-1:0] starve_cnt;

  assign arb_en  = (state != ST_BURST);
  assign promote = (starve_cnt == STARVE_MAX);
  assign win_if  = if_req && (promote || (!dm_req && !vm_req));
  assign win_dm  = !win_if && dm_req;
  assign win_vm  = !win_if && !dm_req && vm_req;

  cvp_burst_ctr #(.AW(AW)) u_burst_ctr (
    .Clk1       (Clk1),
    .Reset_n    (Reset_n),
    .load       (ctr_load),
    .advance    (ctr_adv),
    .len        (vm_len),
    .start_addr (vm_addr),
    .beat_addr  (ctr_addr),
    .last       (ctr_last)
  );

  always_ff @(posedge Clk1) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    iss_owner = OWN_NONE;
    iss_we    = 1'b0;
    iss_addr  = '0;
    iss_data  = '0;
    iss_done  = 1'b0;
    ctr_load  = 1'b0;
    ctr_adv   = 1'b0;
    case (state)
      ST_BURST: begin
        iss_owner = OWN_VM;
        iss_we    = burst_we;
        iss_addr  = ctr_addr;
        iss_data  = vm_wdata;
        iss_done  = ctr_last;
        ctr_adv   = 1'b1;
        state_nxt = ctr_last ? ST_IDLE : ST_BURST;
      end
      default: begin
        state_nxt = ST_IDLE;
        if (win_if) begin
          iss_owner = OWN_IF;
          iss_addr  = if_addr;
          state_nxt = ST_SINGLE;
        end else if (win_dm) begin
          iss_owner = OWN_DM;
          iss_we    = dm_we;
          iss_addr  = dm_addr;
          iss_data  = dm_wdata;
          state_nxt = ST_SINGLE;
        end else if (win_vm) begin
          iss_owner = OWN_VM;
          iss_we    = vm_we;
          iss_addr  = vm_addr;
          iss_data  = vm_wdata;
          ctr_load  = 1'b1;
          // a one-beat burst finishes on its first beat
          iss_done  = (vm_len == 4'd1);
          state_nxt = iss_done ? ST_SINGLE : ST_BURST;
        end
      end
    endcase
  end

  always_ff @(posedge Clk1) begin
    if (!Reset_n) begin
      Mem_Addr    <= '0;
      Mem_DataOut <= '0;
      Mem_RD      <= 1'b0;
      Mem_WR      <= 1'b0;
      if_gnt      <= 1'b0;
      dm_gnt      <= 1'b0;
      vm_gnt      <= 1'b0;
      vm_done     <= 1'b0;
      if_valid    <= 1'b0;
      dm_valid    <= 1'b0;
      vm_valid    <= 1'b0;
      rdata       <= '0;
      rd_owner    <= OWN_NONE;
      burst_we    <= 1'b0;
      starve_cnt  <= '0;
    end else begin
      Mem_RD  <= (iss_owner != OWN_NONE) && !iss_we;
      Mem_WR  <= (iss_owner != OWN_NONE) && iss_we;
      if (iss_owner != OWN_NONE) begin
        Mem_Addr    <= iss_addr;
        Mem_DataOut <= iss_data;
      end
      if_gnt   <= (iss_owner == OWN_IF);
      dm_gnt   <= (iss_owner == OWN_DM);
      vm_gnt   <= (iss_owner == OWN_VM);
      vm_done  <= iss_done;
      // RAM data for the read in flight is valid during its RD cycle
      rd_owner <= iss_we ? OWN_NONE : iss_owner;
      if_valid <= (rd_owner == OWN_IF);
      dm_valid <= (rd_owner == OWN_DM);
      vm_valid <= (rd_owner == OWN_VM);
      if (rd_owner != OWN_NONE) rdata <= Mem_DataIn;
      if (ctr_load) burst_we <= vm_we;
      if (arb_en) begin
        if (!if_req || win_if)  starve_cnt <= '0;
        else if (!promote)      starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

endmodule

// File: doc/cvp_mem_arbiter.md
# cvp_mem_arbiter

Single-port arbiter and sequencer sharing the `staticram` between three CVP14 requesters: instruction fetch (IF, read-only), scalar data (DM, read/write) and vector unit (VM, read/write bursts). It sits between the processor-side request ports and the RAM's `Addr`/`RD`/`WR`/`DataIn`/`DataOut` pins. It issues at most one RAM access per cycle, registers every RAM strobe, and returns read data with a per-port valid.

## Interface
- `AW`, 16, address width
- `DW`, 16, data width
- `STARVE`, 4, consecutive losing cycles after which IF is promoted
- `Clk1`  in  1  single clock; all logic on rising edge
- `Reset_n`  in  1  synchronous, active-low reset
- `if_req`, `if_addr`  in  1/AW  fetch read request and address
- `if_gnt`, `if_valid`  out  1/1  access issued this cycle / read data valid this cycle
- `dm_req`, `dm_we`, `dm_addr`, `dm_wdata`  in  1/1/AW/DW  scalar request
- `dm_gnt`, `dm_valid`  out  1/1  as for IF; `dm_valid` only for reads
- `vm_req`, `vm_we`, `vm_addr`, `vm_len`, `vm_wdata`  in  1/1/AW/4/DW  burst request; `vm_len`=0 means 16 beats
- `vm_gnt`, `vm_valid`, `vm_done`  out  1  beat issued / read beat valid / final beat issued
- `rdata`  out  DW  shared read-return bus, qualified by the `*_valid` signals
- `Mem_Addr`, `Mem_DataOut`, `Mem_RD`, `Mem_WR`  out  AW/DW/1/1  to RAM
- `Mem_DataIn`  in  DW  from RAM

## Operation
- States: IDLE, SINGLE, BURST.
- Arbitration is evaluated at each edge when the state is IDLE, or SINGLE with no burst pending.
- Priority order: DM > VM > IF.
- Exception: when `starve_cnt` == `STARVE`, IF beats both DM and VM.
- Request sampling: at the winning edge, the arbiter registers the address, data and `we` into `Mem_*`. The winner's `*_gnt` is high for the following cycle (the RAM cycle).
- A requester holds its `req` and all inputs stable until it sees its `gnt`.
- A requester may re-request in the `gnt` cycle. It can then be granted back-to-back, one access per cycle.
- SINGLE: one IF or DM access. The state returns to IDLE or immediately issues the next winner.
- BURST:
  - A VM win loads `beat_cnt` = `vm_len`−1 (mod 16) and `burst_addr` = `vm_addr`.
  - Each cycle issues one beat. `burst_addr` increments mod 2^AW and wraps FFFF→0000.
  - `vm_wdata` for beat k is sampled at the edge that issues beat k. The requester advances its data on seeing `vm_gnt`.
  - A burst is non-interruptible. `vm_done` is high alongside `vm_gnt` on the last beat. The state then goes to IDLE and arbitration resumes at that edge.
- Starvation:
  - `starve_cnt` increments on each arbitration edge where `if_req` is high and IF loses.
  - It clears when IF is granted or `if_req` is low, and saturates at `STARVE`.
  - Cycles spent inside a burst do not count.
- A write never produces `*_valid`.
- Reads return data from `Mem_DataIn` onto `rdata` one cycle after the RD cycle, with the owner's valid set. The owner is recorded in a 2-bit `rd_owner` register.

## Timing
- Reset (`Reset_n` low at an edge):
  - next cycle `Mem_RD`=`Mem_WR`=0, `Mem_Addr`=0, `Mem_DataOut`=0
  - all `gnt`/`valid`/`done` outputs are 0
  - state=IDLE, counters=0
  - an in-flight read's valid is suppressed
- Latency: request sampled at edge E; strobes and `gnt` are driven in cycle E+1; read data is valid in cycle E+2 (RAM read latency is one cycle).
- A 16-beat burst occupies exactly 16 consecutive RAM cycles. Read valids trail the beats by one cycle each.
- Simultaneous `dm_req` and `vm_req` with the IF counter below `STARVE`: DM wins and VM waits.
- Reset mid-burst aborts the remaining beats. No `vm_done` is produced.

## Structure
- Shared package `cvp_mem_pkg`:
  - state enum {IDLE, SINGLE, BURST}
  - owner encoding {NONE, IF, DM, VM}
  - `AW`/`DW` defaults
- One natural sub-module: `cvp_burst_ctr`, covering address increment/wrap and `beat_cnt`/`done` generation. The top level holds the arbitration logic and the registered RAM interface.

## Test plan
- Reset, then DM read at 0x0010 with RAM[0x0010]=0xBEEF:
  - `dm_gnt` in cycle 2, `Mem_RD`=1 and `Mem_Addr`=0x0010 in the same cycle
  - `dm_valid` with `rdata`=0xBEEF in cycle 3
- Simultaneous `if_req`, `dm_req`, `vm_req`:
  - DM is granted first, then the VM burst
  - IF is promoted after 4 losses and granted before a repeated DM request
- VM write burst with `vm_len`=0 at 0xFFF8:
  - 16 `Mem_WR` cycles on addresses FFF8..FFFF, 0000..0007
  - `vm_done` only on the 16th beat
- VM read burst with `vm_len`=3 while DM requests:
  - DM waits until after `vm_done`
  - three `vm_valid` beats appear in order
- `Reset_n` asserted on beat 5 of a 16-beat burst:
  - strobes are low the next cycle, no `vm_done`
  - state is IDLE afterwards
- Back-to-back IF reads while `if_req` is held high: one `Mem_RD` per cycle, `if_valid` high on consecutive cycles.
